// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// encoding and the request legality rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  // Stores have no unsigned variants, so bu/hu are legal only for loads.
  function automatic logic lsu_legal(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !addr_lo[0];
      F3_HU:   ok = !we && !addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane steering: extracts and extends sub-word load data, and
// merges sub-word store data into the word read back from RAM.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Each byte lane picks new data only when the addressed byte/half covers it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = gi;
      logic byte_hit;
      logic half_hit;
      assign byte_hit = (funct3 == F3_B) && (addr_lo == LANE);
      assign half_hit = (funct3 == F3_H) && (addr_lo[1] == LANE[1]);
      assign store_data[gi*8 +: 8] =
          byte_hit          ? wdata[7:0] :
          half_hit          ? (LANE[0] ? wdata[15:8] : wdata[7:0]) :
          (funct3 == F3_W)  ? wdata[gi*8 +: 8] :
                              rdata[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu_mem_master.sv
// RV32 load/store initiator for a word-only, combinational-read RAM; sub-word
// stores are done as read-modify-write.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_reg;
  lsu_state_e        state_next;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wbuf_reg;
  logic [DATA_W-1:0] resp_rdata_reg;
  logic              resp_err_reg;
  logic              req_legal;
  logic [31:0]       load_data;
  logic [31:0]       store_data;

  assign req_legal = lsu_legal(req_we, req_funct3, req_addr[1:0]);

  lsu_byte_lane u_lane (
    .funct3     (funct3_reg),
    .addr_lo    (addr_reg[1:0]),
    .rdata      (mem_rdata),
    .wdata      (wbuf_reg),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_legal)             state_next = ST_RESP;
          else if (!req_we)           state_next = ST_LOAD;
          else if (req_funct3 == F3_W) state_next = ST_WRITE;
          else                        state_next = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_next = ST_RESP;
      ST_RMW_RD: state_next = ST_WRITE;
      ST_WRITE:  state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // wbuf holds raw store data until the RMW read replaces it with the merged word.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_reg     <= '0;
      addr_reg       <= '0;
      wbuf_reg       <= '0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            funct3_reg     <= req_funct3;
            addr_reg       <= req_addr;
            wbuf_reg       <= req_wdata;
            resp_rdata_reg <= '0;
            resp_err_reg   <= !req_legal;
          end
        end
        ST_LOAD:   resp_rdata_reg <= load_data;
        ST_RMW_RD: wbuf_reg       <= store_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      ST_IDLE: req_ready = 1'b1;
      ST_LOAD, ST_RMW_RD: begin
        mem_read = 1'b1;
        mem_addr = {addr_reg[ADDR_W-1:2], 2'b00};
      end
      ST_WRITE: begin
        mem_write = !rst;
        mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
        mem_wdata = wbuf_reg;
      end
      ST_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master against a small word-RAM model.
module tb_lsu_mem_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic        preload;

  logic [31:0] ram [0:255];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          nresp = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) ram[64] <= 32'h8081_7F01;
    else if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr[9:2]];

  lsu_mem_master dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
      end
      if (mem_read && mem_write) chk("strobe_overlap", 32'd1, 32'd0);
      if (resp_valid) begin
        nresp++;
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("resp %0d: rdata=0x%08h err=%0b lat=%0d rd=%0d wr=%0d",
                   nresp, resp_rdata, resp_err, cyc - e.acc, rd_cnt, wr_cnt);
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          chk("latency", cyc - e.acc, e.lat);
          chk("mem_read_cycles", rd_cnt, e.nrd);
          chk("mem_write_cycles", wr_cnt, e.nwr);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                       input int lat, input int nrd, input int nwr, input bit keep,
                       output int acc);
    exp_t e;
    acc = -1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    e.rdata = erd; e.err = eerr; e.lat = lat; e.nrd = nrd; e.nwr = nwr; e.acc = cyc;
    acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) chk("resp_timeout", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int a0, a1;
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; preload = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // loads from preloaded word 0x80817F01
    issue(0, 3'b010, 32'h100, 0, 32'h8081_7F01, 0, 2, 1, 0, 0, a0); wait_done();
    issue(0, 3'b000, 32'h103, 0, 32'hFFFF_FF80, 0, 2, 1, 0, 0, a0); wait_done();
    issue(0, 3'b100, 32'h103, 0, 32'h0000_0080, 0, 2, 1, 0, 0, a0); wait_done();
    issue(0, 3'b001, 32'h102, 0, 32'hFFFF_8081, 0, 2, 1, 0, 0, a0); wait_done();
    issue(0, 3'b101, 32'h100, 0, 32'h0000_7F01, 0, 2, 1, 0, 0, a0); wait_done();
    issue(0, 3'b000, 32'h101, 0, 32'h0000_007F, 0, 2, 1, 0, 0, a0); wait_done();

    // byte store via read-modify-write
    issue(1, 3'b000, 32'h101, 32'h0000_00AB, 0, 0, 3, 1, 1, 0, a0); wait_done();
    chk("ram_after_sb", ram[64], 32'h8081_AB01);
    issue(0, 3'b010, 32'h100, 0, 32'h8081_AB01, 0, 2, 1, 0, 0, a0); wait_done();

    // illegal requests: no RAM access, error after one cycle
    issue(0, 3'b010, 32'h102, 0, 0, 1, 1, 0, 0, 0, a0); wait_done();
    issue(1, 3'b001, 32'h101, 32'h1234, 0, 1, 1, 0, 0, 0, a0); wait_done();
    issue(0, 3'b011, 32'h100, 0, 0, 1, 1, 0, 0, 0, a0); wait_done();
    issue(1, 3'b100, 32'h100, 32'h55, 0, 1, 1, 0, 0, 0, a0); wait_done();
    chk("ram_after_errors", ram[64], 32'h8081_AB01);

    // reset during the WRITE cycle of sh 0x100 aborts the store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h100; req_wdata = 32'h1234;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    chk("ram_after_abort", ram[64], 32'h8081_AB01);
    repeat (4) @(negedge clk);
    $display("abort: sh 0x100 reset in WRITE, ram=0x%08h", ram[64]);

    // upper-half store, then read it back
    issue(1, 3'b001, 32'h102, 32'hFFFF_5678, 0, 0, 3, 1, 1, 0, a0); wait_done();
    chk("ram_after_sh", ram[64], 32'h5678_AB01);
    issue(0, 3'b101, 32'h102, 0, 32'h0000_5678, 0, 2, 1, 0, 0, a0); wait_done();

    // back-to-back with req_valid held
    issue(1, 3'b010, 32'h104, 32'hDEAD_BEEF, 0, 0, 2, 0, 1, 1, a0);
    issue(0, 3'b010, 32'h104, 0, 32'hDEAD_BEEF, 0, 2, 1, 0, 0, a1);
    wait_done();
    chk("held_accept_gap", a1 - a0, 32'd3);
    chk("ram_after_sw", ram[65], 32'hDEAD_BEEF);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
